// File: rtl/tof_pkg.sv
// Shared types and helpers for the Toffoli undo engine: gate record, FSM
// encoding and the gate-apply function also used by datapath models.
package tof_pkg;

    localparam int TOF_WIDTH = 8;
    localparam int TOF_DEPTH = 16;
    localparam int TOF_IW    = $clog2(TOF_WIDTH);
    localparam int TOF_CW    = $clog2(TOF_DEPTH + 1);

    typedef struct packed {
        logic [TOF_IW-1:0] c0;
        logic [TOF_IW-1:0] c1;
        logic [TOF_IW-1:0] t;
    } tof_gate_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UNDO = 2'd1,
        ST_DONE = 2'd2
    } tof_state_e;

    function automatic logic [TOF_WIDTH-1:0] tof_apply(input logic [TOF_WIDTH-1:0] s,
                                                       input tof_gate_t g);
        logic [TOF_WIDTH-1:0] r;
        r      = s;
        r[g.t] = s[g.t] ^ (s[g.c0] & s[g.c1]);
        return r;
    endfunction

    // A gate is degenerate when the target aliases a control or an index is off the end.
    function automatic logic tof_gate_bad(input tof_gate_t g);
        logic [TOF_IW:0] lim;
        lim = (TOF_IW + 1)'(TOF_WIDTH);
        return (g.t == g.c0) || (g.t == g.c1) ||
               ({1'b0, g.c0} >= lim) || ({1'b0, g.c1} >= lim) || ({1'b0, g.t} >= lim);
    endfunction

endpackage

// File: rtl/tof_lifo.sv
// LIFO gate log for the undo engine: push, pop, top-of-stack, occupancy and
// synchronous clear. Clear wins over push, push over pop.
module tof_lifo #(
    parameter int DEPTH = 16,
    parameter int EW    = 9,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] din,
    output logic [EW-1:0] top,
    output logic [CW-1:0] depth,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [EW-1:0] mem_r [DEPTH];
    logic [CW-1:0] cnt_r;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] top_idx_s;

    assign wr_idx_s  = AW'(cnt_r);
    assign top_idx_s = AW'(cnt_r - CW'(1));
    assign full      = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == CW'(0));
    assign depth     = cnt_r;
    assign top       = empty ? {EW{1'b0}} : mem_r[top_idx_s];

    // Occupancy counter; refuses to move past either end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CW'(0);
        end else if (clr) begin
            cnt_r <= CW'(0);
        end else if (push && !full) begin
            cnt_r <= cnt_r + CW'(1);
        end else if (pop && !empty) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Entry storage; contents above the count are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (!clr && push && !full) begin
            mem_r[wr_idx_s] <= din;
        end
    end

endmodule

// File: rtl/tof_undo_engine.sv
// Sequential Toffoli executor with a LIFO undo log. Optional gate legality
// checking is enabled by defining TOF_UNDO_GATE_CHECK_EN.
module tof_undo_engine
    import tof_pkg::*;
#(
    parameter int WIDTH = TOF_WIDTH,
    parameter int DEPTH = TOF_DEPTH,
    parameter int IW    = $clog2(WIDTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             gate_valid,
    output logic             gate_ready,
    input  logic [IW-1:0]    gate_c0,
    input  logic [IW-1:0]    gate_c1,
    input  logic [IW-1:0]    gate_t,
    input  logic             undo_start,
    input  logic [CW-1:0]    undo_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    depth,
    output logic [WIDTH-1:0] state_out
);
    localparam int EW = $bits(tof_gate_t);

    tof_state_e       fsm_r, fsm_nx_s;
    logic [WIDTH-1:0] state_r, state_nx_s;
    logic [CW-1:0]    remain_r, remain_nx_s;
    logic             busy_r, done_r, err_r;
    logic             err_nx_s;
    logic             push_s, pop_s, clr_s;
    logic             full_s, empty_s;
    logic [CW-1:0]    depth_s;
    logic [CW-1:0]    n_s;
    logic             reject_s;
    tof_gate_t        gate_s, top_s;
    logic [EW-1:0]    top_raw_s;

    assign gate_s = '{c0: gate_c0, c1: gate_c1, t: gate_t};
    assign top_s  = tof_gate_t'(top_raw_s);

`ifdef TOF_UNDO_GATE_CHECK_EN
    assign reject_s = tof_gate_bad(gate_s);
`else
    assign reject_s = 1'b0;
`endif

    assign n_s = ((undo_count == CW'(0)) || (undo_count > depth_s)) ? depth_s : undo_count;
    assign gate_ready = (fsm_r == ST_IDLE) && !full_s && !load_valid && !undo_start;

    tof_lifo #(.DEPTH(DEPTH), .EW(EW), .CW(CW)) u_log (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .push  (push_s),
        .pop   (pop_s),
        .din   (gate_s),
        .top   (top_raw_s),
        .depth (depth_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-state, datapath and log control.
    always_comb begin
        fsm_nx_s    = fsm_r;
        state_nx_s  = state_r;
        remain_nx_s = remain_r;
        err_nx_s    = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clr_s       = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                if (load_valid) begin
                    state_nx_s = load_data;
                    clr_s      = 1'b1;
                end else if (undo_start) begin
                    remain_nx_s = n_s;
                    fsm_nx_s    = (n_s == CW'(0)) ? ST_DONE : ST_UNDO;
                end else if (gate_valid && gate_ready) begin
                    if (reject_s) begin
                        err_nx_s = 1'b1;
                    end else begin
                        state_nx_s = tof_apply(state_r, gate_s);
                        push_s     = 1'b1;
                    end
                end else begin
                    fsm_nx_s = ST_IDLE;
                end
            end
            ST_UNDO: begin
                // Toffoli is self-inverse: re-applying the logged gate undoes it.
                pop_s       = !empty_s;
                state_nx_s  = empty_s ? state_r : tof_apply(state_r, top_s);
                remain_nx_s = remain_r - CW'(1);
                if ((remain_r <= CW'(1)) || empty_s) begin
                    fsm_nx_s = ST_DONE;
                end else begin
                    fsm_nx_s = ST_UNDO;
                end
            end
            ST_DONE: begin
                fsm_nx_s = ST_IDLE;
            end
            default: begin
                fsm_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r    <= ST_IDLE;
            state_r  <= {WIDTH{1'b0}};
            remain_r <= CW'(0);
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            fsm_r    <= fsm_nx_s;
            state_r  <= state_nx_s;
            remain_r <= remain_nx_s;
            busy_r   <= (fsm_nx_s != ST_IDLE);
            done_r   <= (fsm_nx_s == ST_DONE);
            err_r    <= err_nx_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign depth     = depth_s;
    assign state_out = state_r;

endmodule

// File: tb/tb_tof_undo_engine.sv
// Directed self-checking bench for tof_undo_engine with hand-computed expectations.
module tb_tof_undo_engine;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int IW    = 3;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             gate_valid = 1'b0;
    logic             gate_ready;
    logic [IW-1:0]    gate_c0 = '0, gate_c1 = '0, gate_t = '0;
    logic             undo_start = 1'b0;
    logic [CW-1:0]    undo_count = '0;
    logic             busy, done, err;
    logic [CW-1:0]    depth;
    logic [WIDTH-1:0] state_out;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    tof_undo_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .gate_valid(gate_valid), .gate_ready(gate_ready),
        .gate_c0(gate_c0), .gate_c1(gate_c1), .gate_t(gate_t),
        .undo_start(undo_start), .undo_count(undo_count),
        .busy(busy), .done(done), .err(err), .depth(depth), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d);
        load_valid = 1'b1; load_data = d;
        step();
        load_valid = 1'b0;
    endtask

    task automatic do_gate(input int c0, input int c1, input int t);
        gate_valid = 1'b1;
        gate_c0 = IW'(c0); gate_c1 = IW'(c1); gate_t = IW'(t);
        step();
        gate_valid = 1'b0;
    endtask

    task automatic start_undo(input int n);
        undo_start = 1'b1; undo_count = CW'(n);
        step();
        undo_start = 1'b0; undo_count = '0;
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", state_out, 32'h0);
        chk("rst_depth", depth, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_ready", gate_ready, 32'd1);

        // Basic gate and undo-all
        do_load(8'b0000_0011);
        chk("load_state", state_out, 32'h03);
        do_gate(0, 1, 2);
        chk("g1_state", state_out, 32'h07);
        chk("g1_depth", depth, 32'd1);
        start_undo(0);
        chk("u1_busy", busy, 32'd1);
        chk("u1_done_early", done, 32'd0);
        step();
        chk("u1_state", state_out, 32'h03);
        chk("u1_depth", depth, 32'd0);
        chk("u1_done", done, 32'd1);
        step();
        chk("u1_done_clr", done, 32'd0);
        chk("u1_idle", busy, 32'd0);

        // Empty-log undo goes straight to DONE
        start_undo(0);
        chk("u0_done", done, 32'd1);
        chk("u0_busy", busy, 32'd1);
        step();
        chk("u0_idle", busy, 32'd0);

        // Partial undo: FF -> FB FA FA FB 7B, undo top 2 -> FB then FA
        do_load(8'hFF);
        do_gate(0, 1, 2); chk("p_g1", state_out, 32'hFB);
        do_gate(3, 4, 0); chk("p_g2", state_out, 32'hFA);
        do_gate(0, 1, 5); chk("p_g3", state_out, 32'hFA);
        do_gate(1, 3, 0); chk("p_g4", state_out, 32'hFB);
        do_gate(0, 1, 7); chk("p_g5", state_out, 32'h7B);
        chk("p_depth5", depth, 32'd5);
        start_undo(2);
        step();
        chk("p_pop1", state_out, 32'hFB);
        chk("p_pop1_depth", depth, 32'd4);
        step();
        chk("p_pop2", state_out, 32'hFA);
        chk("p_depth3", depth, 32'd3);
        chk("p_done", done, 32'd1);
        step();

        // Fill the log: 15x {0,1,2} toggles bit2 to 07, then {0,1,3} gives 0F
        do_load(8'h03);
        for (int i = 0; i < 15; i++) do_gate(0, 1, 2);
        chk("f_15", state_out, 32'h07);
        do_gate(0, 1, 3);
        chk("f_16", state_out, 32'h0F);
        chk("f_depth", depth, 32'd16);
        gate_valid = 1'b1; gate_c0 = 3'd0; gate_c1 = 3'd1; gate_t = 3'd2;
        #1 chk("f_ready_low", gate_ready, 32'd0);
        step();
        gate_valid = 1'b0;
        chk("f_state_hold", state_out, 32'h0F);
        chk("f_depth_hold", depth, 32'd16);
        start_undo(0);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            if (done) seen = 1; else step();
        end
        chk("f_done_seen", seen, 32'd1);
        chk("f_restored", state_out, 32'h03);
        chk("f_empty", depth, 32'd0);
        step();

        // Priority: load beats undo and gate
        do_gate(0, 1, 2);
        chk("pr_pre", state_out, 32'h07);
        load_valid = 1'b1; load_data = 8'h55;
        undo_start = 1'b1; undo_count = '0;
        gate_valid = 1'b1; gate_c0 = 3'd0; gate_c1 = 3'd2; gate_t = 3'd3;
        #1 chk("pr_ready", gate_ready, 32'd0);
        step();
        load_valid = 1'b0; undo_start = 1'b0; gate_valid = 1'b0;
        chk("pr_state", state_out, 32'h55);
        chk("pr_depth", depth, 32'd0);
        chk("pr_busy", busy, 32'd0);
        step();
        chk("pr_done", done, 32'd0);

        // Reset mid-undo after 3 of 10 pops; count above depth clamps
        do_load(8'h03);
        for (int i = 0; i < 10; i++) do_gate(0, 1, 2);
        chk("r_depth10", depth, 32'd10);
        start_undo(12);
        repeat (3) step();
        chk("r_depth7", depth, 32'd7);
        chk("r_state", state_out, 32'h07);
        chk("r_busy", busy, 32'd1);
        rst = 1'b1;
        #1;
        chk("r_state0", state_out, 32'h0);
        chk("r_depth0", depth, 32'd0);
        chk("r_busy0", busy, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("r_ready", gate_ready, 32'd1);

        // Degenerate gate {2,3,2}
        do_load(8'h0C);
        do_gate(2, 3, 2);
`ifdef TOF_UNDO_GATE_CHECK_EN
        chk("d_state", state_out, 32'h0C);
        chk("d_depth", depth, 32'd0);
        chk("d_err", err, 32'd1);
`else
        chk("d_state", state_out, 32'h08);
        chk("d_depth", depth, 32'd1);
        chk("d_err", err, 32'd0);
`endif
        step();
        chk("d_err_clr", err, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/tof_undo_engine.md
# tof_undo_engine

Sequential Toffoli gate executor with an undo log, the inverse-direction companion to the combinational Toffoli cell. Forward gates are applied to an internal WIDTH-bit state register and pushed onto a LIFO log. On command, logged gates are popped and re-applied in reverse order, one per cycle; Toffoli is self-inverse, so this restores earlier state. It sits between the instruction sequencer and the reversible datapath register file as the uncompute engine.

## Interface
- WIDTH, 8, state register bits (≥3)
- DEPTH, 16, log entries
- IW, $clog2(WIDTH), derived gate-index width
- CW, $clog2(DEPTH+1), derived count width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- load_valid  in  1  load state register from load_data
- load_data  in  WIDTH  new state
- gate_valid  in  1  forward gate offered
- gate_ready  out  1  gate accepted this cycle when both high
- gate_c0, gate_c1, gate_t  in  IW each  control, control, target indices
- undo_start  in  1  begin undo
- undo_count  in  CW  gates to undo; 0 means all
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at undo completion
- err  out  1  one-cycle pulse on rejected gate
- depth  out  CW  entries in log
- state_out  out  WIDTH  current state register

## Operation
- FSM states: IDLE, UNDO, DONE.
- IDLE input priority per cycle: load_valid > undo_start > gate. Lower-priority requests that cycle are ignored.
- Load: state ← load_data, log cleared (depth ← 0).
- gate_ready = IDLE & depth<DEPTH & !load_valid & !undo_start.
- Accepted gate: state[t] ← state[t] ^ (state[c0] & state[c1]); entry {c0,c1,t} pushed; depth+1.
- Full log: gate_ready low, no overflow, no drop of existing entries.
- undo_start latches n = (undo_count==0 || undo_count>depth) ? depth : undo_count.
  - n=0 → DONE directly.
  - Else → UNDO.
- UNDO: each cycle pop top entry and apply the same gate to state; depth−1; after the n-th pop → DONE.
- DONE: done=1 for one cycle → IDLE.
- gate_valid, load_valid and undo_start are ignored while busy.
- Reset (any time, including mid-undo): state_out=0, depth=0, FSM=IDLE, busy=0, done=0, err=0. gate_ready therefore asserts in the first cycle after reset.

## Timing
- Gate accepted at edge E: state_out and depth are updated after E. Throughput is 1 gate/cycle.
- Load at edge E: state_out = load_data after E.
- Undo of n≥1 gates started at edge E:
  - Pops occur at edges E+1 … E+n.
  - done is high in the cycle after E+n.
  - IDLE after E+n+1.
- Undo with n=0: done is high in the cycle after E.
- busy is high from after E until done deasserts.
- err pulses the cycle after the rejected offer.

## Configuration
- TOF_UNDO_GATE_CHECK_EN defined:
  - A gate is rejected if t==c0, t==c1, or any index ≥WIDTH.
  - Rejection: handshake completes, state and log unchanged, err pulses.
- Undefined:
  - No check; err tied 0.
  - Degenerate gates are applied and logged as-is; their reversibility is not guaranteed.

## Structure
- Package tof_pkg contains:
  - tof_gate_t struct {c0,c1,t}
  - FSM state enum
  - function tof_apply(state, gate) shared with datapath models
- Sub-module tof_lifo holds the log storage: push, pop, top, depth, full/empty, synchronous clear. The engine contains the FSM, count latch and state register.

## Test plan
- Reset, load 8'b0000_0011, gate {0,1,2} → state_out 8'b0000_0111, depth 1. undo_start, count 0 → state 8'b0000_0011, done after 2 cycles, depth 0.
- Load 8'hFF, push 5 gates, undo_count 2 → only the top 2 are undone, in reverse order; depth 3; state matches the golden model after the 3rd gate.
- Fill log to DEPTH=16 → gate_ready low on the 17th offer; state unchanged; undo all restores the load value.
- Same cycle load_valid, undo_start and gate_valid → load wins, depth 0, no busy, gate not applied.
- Assert rst mid-UNDO after 3 of 10 pops → state_out 0, depth 0, busy 0; next cycle gate_ready=1.
- With TOF_UNDO_GATE_CHECK_EN, gate {2,3,2} → err pulse, state and depth unchanged. Without the macro, the same gate is applied and depth increments.
